// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder: one full-adder cell walked LSB-first over WIDTH cycles.
// Optional two's-complement overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_out;

    assign w_sum_bit   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_carry_out = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);
    assign w_accept    = (r_state == S_IDLE) && in_valid;
    assign w_last      = (r_state == S_RUN) && (r_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next_state = S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    // Result registers are separate from sum_sh so sum/cout stay frozen while the next operation shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= {w_sum_bit, r_sum_sh[WIDTH-1:1]};
            r_carry  <= w_carry_out;
            if (w_last) begin
                r_sum  <= {w_sum_bit, r_sum_sh[WIDTH-1:1]};
                r_cout <= w_carry_out;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // At the last bit r_carry is the carry into the sign bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_carry_out;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus helper: called 1 time unit after a rising edge with the DUT in IDLE.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                         output logic [W-1:0] s, output logic co, output logic ov,
                         output int lat, output int bsy);
        a = ta; b = tbv; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bsy = busy ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (busy) bsy++;
        end
        s = sum; co = cout; ov = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a = 8'h5A; b = 8'hA5; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sum !== 8'h00)      begin n_fail++; $display("FAIL reset_sum: got %h want 00", sum); end
        n_checks++; if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b want 0", cout); end
        n_checks++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic [W-1:0] s; logic co, ov; int lat, bsy;
        do_op(8'h0F, 8'h01, 1'b0, s, co, ov, lat, bsy);
        n_checks++; if (s !== 8'h10)  begin n_fail++; $display("FAIL lat_sum: got %h want 10", s); end
        n_checks++; if (co !== 1'b0)  begin n_fail++; $display("FAIL lat_cout: got %b want 0", co); end
        n_checks++; if (lat !== 8)    begin n_fail++; $display("FAIL lat_cycles: got %0d want 8", lat); end
        n_checks++; if (bsy !== 8)    begin n_fail++; $display("FAIL lat_busy_cycles: got %0d want 8", bsy); end
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL lat_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        n_checks++; if (sum !== 8'h10) begin n_fail++; $display("FAIL lat_sum_hold: got %h want 10", sum); end
    endtask

    task automatic test_carry();
        logic [W-1:0] s; logic co, ov; int lat, bsy;
        do_op(8'hFF, 8'h01, 1'b0, s, co, ov, lat, bsy);
        n_checks++; if (s !== 8'h00) begin n_fail++; $display("FAIL carry1_sum: got %h want 00", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL carry1_cout: got %b want 1", co); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL carry1_ovf: got %b want 0", ov); end
        do_op(8'hFF, 8'hFF, 1'b1, s, co, ov, lat, bsy);
        n_checks++; if (s !== 8'hFF) begin n_fail++; $display("FAIL carry2_sum: got %h want ff", s); end
        n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL carry2_cout: got %b want 1", co); end
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL carry2_ovf: got %b want 0", ov); end
        n_checks++; if (lat !== 8)   begin n_fail++; $display("FAIL carry2_lat: got %0d want 8", lat); end
    endtask

    task automatic test_ovf();
        logic [W-1:0] s; logic co, ov; int lat, bsy;
        do_op(8'h7F, 8'h01, 1'b0, s, co, ov, lat, bsy);
        n_checks++; if (s !== 8'h80)   begin n_fail++; $display("FAIL ovf_sum: got %h want 80", s); end
        n_checks++; if (co !== 1'b0)   begin n_fail++; $display("FAIL ovf_cout: got %b want 0", co); end
        n_checks++; if (ov !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ov, OVF_EN); end
    endtask

    task automatic test_backpressure();
        int waited;
        a = 8'h3C; b = 8'h4B; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done: out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = 8'(i * 29 + 7); b = 8'(i * 53 + 1); cin = ~cin;
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready);
            end
            n_checks++; if (sum !== 8'h88 || cout !== 1'b0 || ovf !== OVF_EN) begin
                n_fail++; $display("FAIL bp_result_%0d: sum=%h cout=%b ovf=%b want 88/0/%b", i, sum, cout, ovf, OVF_EN);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        n_checks++; if (sum !== 8'h88) begin n_fail++; $display("FAIL bp_sum_after: got %h want 88", sum); end
    endtask

    task automatic test_reset_midrun();
        logic [W-1:0] s; logic co, ov; int lat, bsy;
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b want 1", busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midrun_abort: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        n_checks++; if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL midrun_clear: sum=%h cout=%b ovf=%b want 00/0/0", sum, cout, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_in_ready: got %b want 1", in_ready); end
        do_op(8'h01, 8'h02, 1'b0, s, co, ov, lat, bsy);
        n_checks++; if (s !== 8'h03 || co !== 1'b0) begin
            n_fail++; $display("FAIL midrun_next: sum=%h cout=%b want 03/0", s, co);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic         qc[$];
        logic [W:0]   exp_full;
        logic [W-1:0] ea, eb;
        logic         ec, eovf;
        int           last_acc, n_acc, n_res;
        last_acc = -1; n_acc = 0; n_res = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = 8'(i * 37 + 5); b = 8'(i * 91 + 3); cin = i[0];
            if (out_valid) begin
                if (qa.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL b2b_unexpected_result: cycle %0d, no pending op", i);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    exp_full = {1'b0, ea} + {1'b0, eb} + {8'b0, ec};
                    eovf = OVF_EN & (ea[7] == eb[7]) & (exp_full[7] != ea[7]);
                    n_checks++; if ({cout, sum} !== exp_full || ovf !== eovf) begin
                        n_fail++; $display("FAIL b2b_result_%0d: cout/sum=%b/%h ovf=%b want %b/%h ovf=%b",
                                           n_res, cout, sum, ovf, exp_full[8], exp_full[7:0], eovf);
                    end
                    n_res++;
                end
            end
            if (in_ready) begin
                qa.push_back(a); qb.push_back(b); qc.push_back(cin);
                if (last_acc >= 0) begin
                    n_checks++; if (i - last_acc !== 10) begin
                        n_fail++; $display("FAIL b2b_period: got %0d want 10", i - last_acc);
                    end
                end
                last_acc = i;
                n_acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (n_acc !== 5) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 5", n_acc); end
        n_checks++; if (n_res !== 5) begin n_fail++; $display("FAIL b2b_results: got %0d want 5", n_res); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        @(posedge clk); #1;
        test_latency();
        test_carry();
        test_ovf();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
